// File: rtl/remote_cmd_arbiter.sv
// Round-robin arbiter sharing one byte-serial command link between NUM_REQ requesters.
// Each grant sends a 16-bit command as two bytes (high first) and returns one response byte or a timeout.
module remote_cmd_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_cmd,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [7:0]             rsp_data,
  output logic                   rsp_timeout,
  output logic                   send_cmd,
  output logic [7:0]             cmd,
  input  logic                   cmd_sent,
  input  logic                   resp_rdy,
  input  logic [7:0]             resp
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, WAIT_RSP, DONE} state_t;

  state_t             state_reg, state_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [NUM_REQ-1:0] done_reg, done_next;
  logic [7:0]         rsp_data_reg, rsp_data_next;
  logic               rsp_timeout_reg, rsp_timeout_next;
  logic               send_cmd_reg, send_cmd_next;
  logic [7:0]         cmd_reg, cmd_next;
  logic [15:0]        cmd_hold_reg, cmd_hold_next;
  logic [PW-1:0]      ptr_reg, ptr_next;
  logic [CW-1:0]      cnt_reg, cnt_next;

  logic [15:0]        req_cmd_arr [NUM_REQ];
  logic               sel_found;
  logic [PW-1:0]      sel_idx;
  logic [PW-1:0]      cand;
  int                 idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cmd_split
      assign req_cmd_arr[gi] = req_cmd[16*gi +: 16];
    end
  endgenerate

  // Scan from farthest to nearest candidate so the one right after the pointer wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PW'(idx);
      if (req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    gnt_next         = gnt_reg;
    done_next        = '0;
    rsp_data_next    = rsp_data_reg;
    rsp_timeout_next = rsp_timeout_reg;
    send_cmd_next    = 1'b0;
    cmd_next         = cmd_reg;
    cmd_hold_next    = cmd_hold_reg;
    ptr_next         = ptr_reg;
    cnt_next         = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          cmd_hold_next = req_cmd_arr[sel_idx];
          gnt_next      = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
          ptr_next      = sel_idx;
          send_cmd_next = 1'b1;
          cmd_next      = req_cmd_arr[sel_idx][15:8];
          state_next    = SEND_HI;
        end
      end
      // cmd_sent is ignored here; the link clears it only after seeing send_cmd.
      SEND_HI: state_next = WAIT_HI;
      WAIT_HI: begin
        if (cmd_sent) begin
          send_cmd_next = 1'b1;
          cmd_next      = cmd_hold_reg[7:0];
          state_next    = SEND_LO;
        end
      end
      SEND_LO: state_next = WAIT_LO;
      WAIT_LO: begin
        if (cmd_sent) begin
          cnt_next   = '0;
          state_next = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        cnt_next = cnt_reg + CW'(1);
        if (resp_rdy) begin
          rsp_data_next    = resp;
          rsp_timeout_next = 1'b0;
          done_next        = gnt_reg;
          state_next       = DONE;
        end else if (cnt_reg == CW'(TIMEOUT_CYC - 1)) begin
          rsp_data_next    = 8'h00;
          rsp_timeout_next = 1'b1;
          done_next        = gnt_reg;
          state_next       = DONE;
        end
      end
      DONE: begin
        gnt_next   = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      gnt_reg         <= '0;
      done_reg        <= '0;
      rsp_data_reg    <= 8'h00;
      rsp_timeout_reg <= 1'b0;
      send_cmd_reg    <= 1'b0;
      cmd_reg         <= 8'h00;
      cmd_hold_reg    <= 16'h0000;
      ptr_reg         <= PW'(NUM_REQ - 1);
      cnt_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      gnt_reg         <= gnt_next;
      done_reg        <= done_next;
      rsp_data_reg    <= rsp_data_next;
      rsp_timeout_reg <= rsp_timeout_next;
      send_cmd_reg    <= send_cmd_next;
      cmd_reg         <= cmd_next;
      cmd_hold_reg    <= cmd_hold_next;
      ptr_reg         <= ptr_next;
      cnt_reg         <= cnt_next;
    end
  end

  assign gnt         = gnt_reg;
  assign done        = done_reg;
  assign rsp_data    = rsp_data_reg;
  assign rsp_timeout = rsp_timeout_reg;
  assign send_cmd    = send_cmd_reg;
  assign cmd         = cmd_reg;

endmodule

// File: tb/tb_remote_cmd_arbiter.sv
// Bench for remote_cmd_arbiter: a link model plus a transaction-level reference
// (round-robin pick, byte order, response/timeout outcome and its cycle).
module tb_remote_cmd_arbiter;
  localparam int NR = 4;
  localparam int TO = 50;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [16*NR-1:0]  req_cmd;
  logic [NR-1:0]     gnt, done;
  logic [7:0]        rsp_data;
  logic              rsp_timeout;
  logic              send_cmd;
  logic [7:0]        cmd;
  logic              cmd_sent;
  logic              resp_rdy;
  logic [7:0]        resp;

  remote_cmd_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .gnt(gnt), .done(done),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .send_cmd(send_cmd), .cmd(cmd),
    .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Link model: clears cmd_sent the cycle after send_cmd, raises it l_cdly cycles
  // after send_cmd, and pulses resp_rdy l_rdly cycles after the second byte completes.
  int         l_cdly = 10;
  int         l_rdly = 5;
  bit         l_ren = 1'b1;
  bit         l_stray = 1'b0;
  logic [7:0] l_rv = 8'h00;
  int         cd = 0;
  int         rsp_cd = 0;
  int         nbytes = 0;
  bit         clr_pend = 1'b0;
  int         r_cyc = 0;
  logic [7:0] byte_q[$];
  int         send_cyc_q[$];

  initial begin
    cmd_sent = 1'b1;
    resp_rdy = 1'b0;
    resp     = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      resp_rdy = 1'b0;
      if (rst) begin
        nbytes = 0;
        rsp_cd = 0;
      end
      if (clr_pend) begin
        clr_pend = 1'b0;
        cmd_sent = 1'b0;
        cd = l_cdly - 1;
        if (l_stray && nbytes == 1) begin
          resp_rdy = 1'b1;
          resp     = 8'h77;
        end
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          cmd_sent = 1'b1;
          if (nbytes == 2) begin
            nbytes = 0;
            r_cyc  = cyc;
            if (l_ren) rsp_cd = l_rdly;
          end
        end
      end else if (rsp_cd > 0) begin
        rsp_cd--;
        if (rsp_cd == 0) begin
          resp_rdy = 1'b1;
          resp     = l_rv;
        end
      end
      if (send_cmd) begin
        byte_q.push_back(cmd);
        send_cyc_q.push_back(cyc);
        nbytes++;
        clr_pend = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0)
      check("onehot_gnt_done", {30'd0, $onehot0(gnt), ((done & ~gnt) == '0)}, 32'd3);
  end

  logic [15:0] cmd_tab [NR];
  int          m_ptr = NR - 1;

  task automatic load_cmds();
    for (int i = 0; i < NR; i++) req_cmd[16*i +: 16] = cmd_tab[i];
  endtask

  task automatic do_txn(input logic [NR-1:0] rq, input int cdly, input bit ren, input int rdly,
                        input logic [7:0] rv, input bit stray, input bit drop);
    int          exp_idx;
    logic [15:0] exp_cmd;
    logic [7:0]  exp_data;
    logic        exp_to;
    int          exp_lat;
    bit          got;
    bit          seen_gnt;
    exp_idx = -1;
    for (int k = 1; k <= NR; k++)
      if (exp_idx < 0 && rq[(m_ptr + k) % NR]) exp_idx = (m_ptr + k) % NR;
    exp_cmd = cmd_tab[exp_idx];
    if (ren && rdly <= TO) begin
      exp_data = rv;    exp_to = 1'b0; exp_lat = rdly + 1;
    end else begin
      exp_data = 8'h00; exp_to = 1'b1; exp_lat = TO + 1;
    end
    byte_q.delete();
    send_cyc_q.delete();
    l_cdly = cdly; l_ren = ren; l_rdly = rdly; l_rv = rv; l_stray = stray;
    load_cmds();
    req = rq;
    got = 1'b0;
    seen_gnt = 1'b0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      if (gnt != '0) begin
        if (!seen_gnt) begin
          seen_gnt = 1'b1;
          check("first_send_with_gnt", send_cmd, 1);
          if (drop) req = '0;
          req_cmd = ~req_cmd;
        end
        check("gnt_hold", gnt, 32'd1 << exp_idx);
      end
      if (done != '0) begin
        got = 1'b1;
        check("done_bit", done, 32'd1 << exp_idx);
        check("rsp_data", rsp_data, exp_data);
        check("rsp_timeout", rsp_timeout, exp_to);
        check("done_latency", cyc - r_cyc, exp_lat);
        check("byte_count", byte_q.size(), 2);
        if (byte_q.size() == 2) begin
          check("byte_hi", byte_q[0], exp_cmd[15:8]);
          check("byte_lo", byte_q[1], exp_cmd[7:0]);
          check("send_gap", send_cyc_q[1] - send_cyc_q[0], cdly + 1);
        end
      end
    end
    if (!got) begin
      check("txn_completed", 0, 1);
    end else begin
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("gnt_released", gnt, 0);
    end
    $display("txn req=%b grant=%0d cmd=%04h rsp=%02h timeout=%0b", rq, exp_idx, exp_cmd, rsp_data, rsp_timeout);
    m_ptr = exp_idx;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_send_cmd"}, send_cmd, 0);
    check({tag, "_cmd"}, cmd, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_timeout"}, rsp_timeout, 0);
  endtask

  initial begin
    bit fired;
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < NR; i++) cmd_tab[i] = 16'h0000;
    load_cmds();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    // Round-robin with all requests held: 0,1,2,3,0
    cmd_tab[0] = 16'h1111; cmd_tab[1] = 16'h2222; cmd_tab[2] = 16'h3333; cmd_tab[3] = 16'h4444;
    for (int n = 0; n < 5; n++) begin
      do_txn(4'b1111, 3, 1'b1, 4, 8'(8'h40 + n), 1'b0, 1'b0);
      check("rr_order", m_ptr, n % NR);
    end

    cmd_tab[0] = 16'hA55A;
    do_txn(4'b0001, 10, 1'b1, 5, 8'h3C, 1'b0, 1'b0);
    do_txn(4'b0001, 4, 1'b1, 2, 8'h91, 1'b0, 1'b0);
    do_txn(4'b0010, 3, 1'b0, 1, 8'hEE, 1'b0, 1'b0);
    do_txn(4'b0100, 8, 1'b1, 6, 8'h12, 1'b1, 1'b0);
    do_txn(4'b1000, 3, 1'b1, TO, 8'h5A, 1'b0, 1'b0);
    do_txn(4'b1000, 3, 1'b1, TO + 1, 8'h5B, 1'b0, 1'b0);
    do_txn(4'b0011, 5, 1'b1, 7, 8'hC3, 1'b0, 1'b1);

    // Reset during WAIT_LO, then requester 2 alone
    req = 4'b0001;
    l_cdly = 10; l_ren = 1'b1; l_rdly = 3; l_stray = 1'b0;
    send_cyc_q.delete();
    load_cmds();
    fired = 1'b0;
    for (int t = 0; t < 100 && !fired; t++) begin
      @(negedge clk);
      if (send_cyc_q.size() >= 2) fired = 1'b1;
    end
    check("reach_wait_lo", fired, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("midop_reset");
    rst = 1'b0;
    req = '0;
    m_ptr = NR - 1;
    do_txn(4'b0100, 6, 1'b1, 4, 8'h2D, 1'b0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      logic [NR-1:0] rq;
      rq = NR'($urandom_range(1, (1 << NR) - 1));
      for (int i = 0; i < NR; i++) cmd_tab[i] = 16'($urandom);
      do_txn(rq, int'($urandom_range(2, 8)), bit'($urandom_range(0, 3) != 0),
             int'($urandom_range(1, TO + 4)), 8'($urandom), bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
